// File: rtl/fir_filter_sym_tdm_if.sv
// Sample/coefficient/result bundle for fir_filter_sym_tdm.
//   master: sample source + coefficient writer (drives valid_in/chan_in/din/coef_*)
//   slave : the filter (drives ready_in and the registered result signals)
// ADDR_W must match max(1,$clog2((NUM_TAPS+1)/2)) of the attached filter and
// CHAN_W must match max(1,$clog2(NUM_CHANNELS)).
interface fir_filter_sym_tdm_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int COEFF_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int CHAN_W       = 2,
  parameter int ADDR_W       = 5
);
  logic                           valid_in;
  logic                           ready_in;
  logic [CHAN_W-1:0]              chan_in;
  logic signed [INPUT_WIDTH-1:0]  din;
  logic                           coef_we;
  logic [ADDR_W-1:0]              coef_addr;
  logic signed [COEFF_WIDTH-1:0]  coef_data;
  logic                           valid_out;
  logic [CHAN_W-1:0]              chan_out;
  logic signed [OUTPUT_WIDTH-1:0] dout;
  logic                           overflow;

  modport master (
    output valid_in, chan_in, din, coef_we, coef_addr, coef_data,
    input  ready_in, valid_out, chan_out, dout, overflow
  );
  modport slave (
    input  valid_in, chan_in, din, coef_we, coef_addr, coef_data,
    output ready_in, valid_out, chan_out, dout, overflow
  );
endinterface

// File: rtl/fir_filter_sym_tdm.sv
// Time-multiplexed multi-channel (anti-)symmetric FIR. One pre-add + multiplier
// walks the S = (NUM_TAPS+1)/2 unique coefficients of the channel just accepted,
// then rounds, saturates and emits a one-cycle result.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fir_filter_sym_tdm_if (sample in, coef write, result out)
module fir_filter_sym_tdm #(
  parameter int INPUT_WIDTH  = 16,
  parameter int COEFF_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_TAPS     = 37,
  parameter int SYMMETRY     = 0,
  parameter logic [0:(NUM_TAPS+1)/2-1][COEFF_WIDTH-1:0] COEFFS = {
    8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h01, 8'hFF, 8'hFD, 8'hFD,
    8'h00, 8'h03, 8'h06, 8'h09, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0E},
  parameter int OUT_SHIFT    = 7
) (
  input logic               clk,
  input logic               rst,
  fir_filter_sym_tdm_if.slave bus
);
  localparam int S     = (NUM_TAPS + 1) / 2;
  localparam int ODD   = NUM_TAPS % 2;
  localparam int AW    = (S > 1) ? $clog2(S) : 1;
  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TW    = $clog2(NUM_TAPS);
  localparam int ACC_W = INPUT_WIDTH + 1 + COEFF_WIDTH + $clog2(S);
  localparam int HS    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  // Extra MSB on the rounded value so the +half never wraps.
  localparam logic signed [ACC_W:0] HALF =
    (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << HS) : '0;
  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'((64'sd1 <<< (OUTPUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nx;
  logic   rdy, take;

  logic [NUM_CHANNELS-1:0][NUM_TAPS-1:0][INPUT_WIDTH-1:0] dl;  // [0] = newest
  logic [S-1:0][COEFF_WIDTH-1:0] shadow, active;
  logic signed [ACC_W-1:0] acc;
  logic [AW-1:0] k_q;
  logic [CW-1:0] ch_q;

  logic [TW-1:0] ka, kb;
  logic signed [INPUT_WIDTH-1:0] xa, xb;
  logic signed [INPUT_WIDTH:0] pre;
  logic signed [INPUT_WIDTH+COEFF_WIDTH:0] prod;
  logic signed [ACC_W:0] accx, r;
  logic [OUTPUT_WIDTH-1:0] sat_val;
  logic sat_ovf;

  logic valid_out_q, overflow_q;
  logic [CW-1:0] chan_out_q;
  logic [OUTPUT_WIDTH-1:0] dout_q;

  // Out-of-range channels are accepted (handshake completes) but discarded.
  assign take = bus.valid_in && rdy && (int'(bus.chan_in) < NUM_CHANNELS);

  // OUT also accepts so back-to-back samples sustain one per S+1 cycles.
  always_comb begin
    state_nx = state;
    rdy      = !rst && (state != MAC);
    case (state)
      IDLE:    if (take) state_nx = MAC;
      MAC:     if (k_q == AW'(S-1)) state_nx = OUT;
      OUT:     state_nx = take ? MAC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Folded term k: x[k] +/- x[N-1-k]; unpaired centre tap for odd N.
  always_comb begin
    ka  = TW'(k_q);
    kb  = TW'(NUM_TAPS-1) - ka;
    xa  = $signed(dl[ch_q][ka]);
    xb  = $signed(dl[ch_q][kb]);
    pre = '0;
    if (ODD != 0 && k_q == AW'(S-1)) begin
      if (SYMMETRY == 0) pre = $signed({xa[INPUT_WIDTH-1], xa});
    end else if (SYMMETRY == 0) begin
      pre = $signed({xa[INPUT_WIDTH-1], xa}) + $signed({xb[INPUT_WIDTH-1], xb});
    end else begin
      pre = $signed({xa[INPUT_WIDTH-1], xa}) - $signed({xb[INPUT_WIDTH-1], xb});
    end
    prod = pre * $signed(active[k_q]);
  end

  // Round half up, arithmetic shift, saturate.
  always_comb begin
    accx    = $signed({acc[ACC_W-1], acc}) + HALF;
    r       = accx >>> OUT_SHIFT;
    sat_ovf = 1'b0;
    sat_val = r[OUTPUT_WIDTH-1:0];
    if (r > MAXV) begin
      sat_ovf = 1'b1;
      sat_val = MAXV[OUTPUT_WIDTH-1:0];
    end else if (r < MINV) begin
      sat_ovf = 1'b1;
      sat_val = MINV[OUTPUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dl          <= '0;
      acc         <= '0;
      k_q         <= '0;
      ch_q        <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      chan_out_q  <= '0;
      dout_q      <= '0;
      for (int i = 0; i < S; i++) begin
        shadow[i] <= COEFFS[i];
        active[i] <= COEFFS[i];
      end
    end else begin
      state       <= state_nx;
      valid_out_q <= 1'b0;
      if (bus.coef_we && int'(bus.coef_addr) < S)
        shadow[bus.coef_addr] <= bus.coef_data;
      if (take) begin
        for (int c = 0; c < NUM_CHANNELS; c++)
          if (int'(bus.chan_in) == c) dl[c] <= {dl[c][NUM_TAPS-2:0], bus.din};
        // Same-edge shadow write is forwarded into the bank this MAC uses.
        for (int i = 0; i < S; i++)
          active[i] <= (bus.coef_we && int'(bus.coef_addr) == i) ? bus.coef_data : shadow[i];
        acc  <= '0;
        k_q  <= '0;
        ch_q <= bus.chan_in;
      end else if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        k_q <= k_q + AW'(1);
      end
      if (state == OUT) begin
        valid_out_q <= 1'b1;
        dout_q      <= sat_val;
        overflow_q  <= sat_ovf;
        chan_out_q  <= ch_q;
      end
    end
  end

  assign bus.ready_in  = rdy;
  assign bus.valid_out = valid_out_q;
  assign bus.dout      = dout_q;
  assign bus.overflow  = overflow_q;
  assign bus.chan_out  = chan_out_q;
endmodule

// File: tb/tb_fir_filter_sym_tdm.sv
// Bench: three 5-tap, 3-unique-coeff filters (u0 symmetric {1,2,3}, u1
// anti-symmetric {1,2,5}, u2 3-channel {1,0,0} with OUT_SHIFT=1). A direct-form
// reference model pushes expected results when a sample is accepted; per-unit
// monitors pop and compare on valid_out.
module tb_fir_filter_sym_tdm;
  localparam int NU = 3, NT = 5, NS = 3, P = 10;

  logic clk = 1'b0;
  logic rst;
  always #(P/2) clk = ~clk;

  fir_filter_sym_tdm_if #(.INPUT_WIDTH(16), .COEFF_WIDTH(8), .OUTPUT_WIDTH(16),
                          .CHAN_W(2), .ADDR_W(2)) bus [NU] ();

  fir_filter_sym_tdm #(.INPUT_WIDTH(16), .COEFF_WIDTH(8), .OUTPUT_WIDTH(16), .NUM_CHANNELS(4),
    .NUM_TAPS(NT), .SYMMETRY(0), .COEFFS({8'd1, 8'd2, 8'd3}), .OUT_SHIFT(0))
    u0 (.clk(clk), .rst(rst), .bus(bus[0]));
  fir_filter_sym_tdm #(.INPUT_WIDTH(16), .COEFF_WIDTH(8), .OUTPUT_WIDTH(16), .NUM_CHANNELS(4),
    .NUM_TAPS(NT), .SYMMETRY(1), .COEFFS({8'd1, 8'd2, 8'd5}), .OUT_SHIFT(0))
    u1 (.clk(clk), .rst(rst), .bus(bus[1]));
  fir_filter_sym_tdm #(.INPUT_WIDTH(16), .COEFF_WIDTH(8), .OUTPUT_WIDTH(16), .NUM_CHANNELS(3),
    .NUM_TAPS(NT), .SYMMETRY(0), .COEFFS({8'd1, 8'd0, 8'd0}), .OUT_SHIFT(1))
    u2 (.clk(clk), .rst(rst), .bus(bus[2]));

  logic              vin [NU];
  logic [1:0]        cin [NU];
  logic signed [15:0] din [NU];
  logic              we  [NU];
  logic [1:0]        wa  [NU];
  logic signed [7:0] wd  [NU];
  wire [NU-1:0]      rdy, vo, ov;
  wire [1:0]         co  [NU];
  wire signed [15:0] dq  [NU];

  typedef struct { int ch; int d; int o; time t; } exp_t;
  exp_t sb [NU][$];

  int hist [NU][4][NT];
  int cf   [NU][NS];
  int symu [NU] = '{0, 1, 0};
  int shu  [NU] = '{0, 0, 1};
  int nch  [NU] = '{4, 4, 3};

  int n_chk = 0, n_ok = 0;

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model_reset();
    foreach (hist[u, c, j]) hist[u][c][j] = 0;
    cf[0] = '{1, 2, 3};
    cf[1] = '{1, 2, 5};
    cf[2] = '{1, 0, 0};
  endfunction

  // Direct-form reference: expand the unique coeffs into the full impulse response.
  function automatic void model_push(int u, int ch, int x);
    longint acc, r;
    int h [NT];
    exp_t e;
    for (int j = NT-1; j > 0; j--) hist[u][ch][j] = hist[u][ch][j-1];
    hist[u][ch][0] = x;
    for (int k = 0; k < NS; k++) begin
      h[k]      = cf[u][k];
      h[NT-1-k] = symu[u] ? -cf[u][k] : cf[u][k];
    end
    if (symu[u] != 0) h[NS-1] = 0;
    acc = 0;
    for (int j = 0; j < NT; j++) acc += longint'(h[j]) * longint'(hist[u][ch][j]);
    r = (shu[u] > 0) ? ((acc + (longint'(1) << (shu[u]-1))) >>> shu[u]) : acc;
    e.o  = (r > 32767 || r < -32768) ? 1 : 0;
    e.d  = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
    e.ch = ch;
    e.t  = $time;
    sb[u].push_back(e);
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_u
    exp_t e;
    assign bus[g].valid_in  = vin[g];
    assign bus[g].chan_in   = cin[g];
    assign bus[g].din       = din[g];
    assign bus[g].coef_we   = we[g];
    assign bus[g].coef_addr = wa[g];
    assign bus[g].coef_data = wd[g];
    assign rdy[g] = bus[g].ready_in;
    assign vo[g]  = bus[g].valid_out;
    assign ov[g]  = bus[g].overflow;
    assign co[g]  = bus[g].chan_out;
    assign dq[g]  = bus[g].dout;

    always @(negedge clk) begin
      if (!rst && vo[g]) begin
        if (sb[g].size() == 0) chk($sformatf("u%0d_unexpected_out", g), 1, 0);
        else begin
          e = sb[g].pop_front();
          chk($sformatf("u%0d_dout", g), dq[g], e.d);
          chk($sformatf("u%0d_chan", g), co[g], e.ch);
          chk($sformatf("u%0d_ovf", g), ov[g], e.o);
          chk($sformatf("u%0d_latency", g), $time - e.t, 4*P + P/2);
        end
      end
    end
  end

  task automatic send(int u, int ch, int x);
    int n = 0;
    @(posedge clk); #1;
    vin[u] = 1'b1; cin[u] = 2'(ch); din[u] = 16'(x);
    @(negedge clk);
    while (!rdy[u] && n < 50) begin n++; @(negedge clk); end
    if (!rdy[u]) chk($sformatf("u%0d_ready_timeout", u), 0, 1);
    else begin
      @(posedge clk);
      if (ch < nch[u]) model_push(u, ch, x);
    end
    #1 vin[u] = 1'b0;
  endtask

  task automatic wr_coef(int u, int a, int d);
    @(posedge clk); #1;
    we[u] = 1'b1; wa[u] = 2'(a); wd[u] = 8'(d);
    @(posedge clk);
    if (a < NS) cf[u][a] = d;
    #1 we[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      vin[u] = 0; cin[u] = 0; din[u] = 0; we[u] = 0; wa[u] = 0; wd[u] = 0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy[0], 0);
    chk("rst_valid_out", vo[0], 0);
    chk("rst_dout", dq[0], 0);
    chk("rst_ovf", ov[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", rdy[0], 1);

    // u0: ch0 impulse interleaved with ch1 zeros.
    send(0, 0, 1); send(0, 1, 0);
    for (int i = 0; i < 4; i++) begin send(0, 0, 0); send(0, 1, 0); end

    // u1: anti-symmetric impulse on ch2.
    send(1, 2, 1);
    for (int i = 0; i < 4; i++) send(1, 2, 0);

    // u2: rounding of +/-3, -4.
    send(2, 0, 3); send(2, 1, -3); send(2, 2, -4);

    // u2: invalid channel held high across a MAC; ch0 delay line must be untouched.
    send(2, 0, 5);
    vin[2] = 1'b1; cin[2] = 2'd3; din[2] = 16'sd1000;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("inv_chan_ready", rdy[2], 1);
      @(negedge clk);
    end
    vin[2] = 1'b0;
    wr_coef(2, 1, 1);
    send(2, 0, 0);

    // u0: coef write mid-MAC only affects the following result; addr S ignored.
    send(0, 1, 1);
    wr_coef(0, 0, 4);
    wr_coef(0, 3, 99);
    send(0, 1, 1);

    // u0: saturation both ways on ch3.
    for (int a = 0; a < NS; a++) wr_coef(0, a, 127);
    for (int i = 0; i < 5; i++) send(0, 3, 32767);
    for (int i = 0; i < 5; i++) send(0, 3, -32768);

    // Reset sampled at E2 of a MAC: result dropped, clean response afterwards.
    send(0, 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    for (int u = 0; u < NU; u++) sb[u].delete();
    model_reset();
    @(negedge clk);
    chk("midmac_rst_ready", rdy[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midmac_post_ready", rdy[0], 1);
    repeat (6) @(negedge clk);
    send(0, 0, 1);
    for (int i = 0; i < 4; i++) send(0, 0, 0);

    repeat (10) @(negedge clk);
    for (int u = 0; u < NU; u++) chk($sformatf("u%0d_sb_drained", u), sb[u].size(), 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
